// File: rtl/sort_mem_responder_if.sv
// Read (AR/R) and write (AW/W/B) handshake bundle between the sort datapath
// and its memory-side responder.
interface sort_mem_responder_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
);
    logic [ADDR_WDTH-1:0] arr_size;

    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;

    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic [RESP_WDTH-1:0] r_resp;

    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;

    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;

    logic                 b_valid;
    logic                 b_ready;
    logic [RESP_WDTH-1:0] b_resp;

    modport master (
        output arr_size,
        output ar_valid, ar_address, input ar_ready,
        input  r_valid, r_data, r_resp, output r_ready,
        output aw_valid, aw_address, input aw_ready,
        output w_valid, w_data, input w_ready,
        input  b_valid, b_resp, output b_ready
    );

    modport slave (
        input  arr_size,
        input  ar_valid, ar_address, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready,
        input  aw_valid, aw_address, output aw_ready,
        input  w_valid, w_data, output w_ready,
        output b_valid, b_resp, input b_ready
    );
endinterface

// File: rtl/sort_mem_responder.sv
// Register-array memory serving one read and one write transaction concurrently;
// addresses at or above arr_size get an error response and never touch storage.
//   state     | meaning
//   R_IDLE    | ready for AR
//   R_RESP    | holding read data/resp until R handshake
//   W_IDLE    | ready for AW and W
//   W_HAVE_AW | address captured, waiting for W
//   W_HAVE_W  | data captured, waiting for AW
//   W_RESP    | holding write response until B handshake
module sort_mem_responder #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input logic                 clk,
    input logic                 rst,
    sort_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WDTH;
    localparam logic [RESP_WDTH-1:0] RESP_OK  = '0;
    localparam logic [RESP_WDTH-1:0] RESP_ERR = RESP_WDTH'(1);

    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;

    r_state_e             r_state_q, r_state_d;
    logic [DATA_WDTH-1:0] r_data_q, r_data_d;
    logic [RESP_WDTH-1:0] r_resp_q, r_resp_d;

    w_state_e             w_state_q, w_state_d;
    logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WDTH-1:0] w_data_q, w_data_d;
    logic [RESP_WDTH-1:0] b_resp_q, b_resp_d;

    logic [DATA_WDTH-1:0] mem_q [DEPTH];

    logic                 ar_ready, r_valid, aw_ready, w_ready, b_valid;
    logic                 commit, mem_we;
    logic [ADDR_WDTH-1:0] commit_addr;
    logic [DATA_WDTH-1:0] commit_data;

    always_comb begin
        r_state_d = r_state_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (bus.ar_valid) begin
                    r_state_d = R_RESP;
                    if (bus.ar_address < bus.arr_size) begin
                        r_data_d = mem_q[bus.ar_address];
                        r_resp_d = RESP_OK;
                    end else begin
                        r_data_d = '0;
                        r_resp_d = RESP_ERR;
                    end
                end
            end
            R_RESP: begin
                r_valid = 1'b1;
                if (bus.r_ready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        b_resp_d    = b_resp_q;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        b_valid     = 1'b0;
        commit      = 1'b0;
        commit_addr = bus.aw_address;
        commit_data = bus.w_data;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                w_ready  = 1'b1;
                if (bus.aw_valid && bus.w_valid) begin
                    commit = 1'b1;
                end else if (bus.aw_valid) begin
                    aw_addr_d = bus.aw_address;
                    w_state_d = W_HAVE_AW;
                end else if (bus.w_valid) begin
                    w_data_d  = bus.w_data;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_ready     = 1'b1;
                commit_addr = aw_addr_q;
                commit      = bus.w_valid;
            end
            W_HAVE_W: begin
                aw_ready    = 1'b1;
                commit_data = w_data_q;
                commit      = bus.aw_valid;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (bus.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        // Range is judged against arr_size as it stands on the commit edge.
        mem_we = commit && (commit_addr < bus.arr_size);
        if (commit) begin
            w_state_d = W_RESP;
            b_resp_d  = mem_we ? RESP_OK : RESP_ERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            b_resp_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            b_resp_q  <= b_resp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[commit_addr] <= commit_data;
        end
    end

    assign bus.ar_ready = ar_ready;
    assign bus.r_valid  = r_valid;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;
    assign bus.aw_ready = aw_ready;
    assign bus.w_ready  = w_ready;
    assign bus.b_valid  = b_valid;
    assign bus.b_resp   = b_resp_q;
endmodule

// File: tb/tb_sort_mem_responder.sv
// Directed bench for sort_mem_responder: read/write paths, ordering, range errors,
// backpressure, read/write collision and mid-transaction reset.
module tb_sort_mem_responder;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    sort_mem_responder_if bus ();

    sort_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic exp_resp);
        bus.aw_valid   = 1'b1;
        bus.aw_address = addr;
        bus.w_valid    = 1'b1;
        bus.w_data     = data;
        bus.b_ready    = 1'b1;
        chk("wr_aw_ready", bus.aw_ready, 1);
        chk("wr_w_ready", bus.w_ready, 1);
        step();
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        chk("wr_b_valid", bus.b_valid, 1);
        chk("wr_b_resp", bus.b_resp, exp_resp);
        step();
        chk("wr_b_done", bus.b_valid, 0);
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp_data, input logic exp_resp);
        bus.ar_valid   = 1'b1;
        bus.ar_address = addr;
        bus.r_ready    = 1'b1;
        chk("rd_ar_ready", bus.ar_ready, 1);
        step();
        bus.ar_valid = 1'b0;
        chk("rd_r_valid", bus.r_valid, 1);
        chk("rd_r_data", bus.r_data, exp_data);
        chk("rd_r_resp", bus.r_resp, exp_resp);
        step();
        chk("rd_r_done", bus.r_valid, 0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst            = 1'b1;
        bus.arr_size   = 4'd8;
        bus.ar_valid   = 1'b0;
        bus.ar_address = '0;
        bus.r_ready    = 1'b0;
        bus.aw_valid   = 1'b0;
        bus.aw_address = '0;
        bus.w_valid    = 1'b0;
        bus.w_data     = '0;
        bus.b_ready    = 1'b0;

        #12;
        chk("rst_ar_ready", bus.ar_ready, 1);
        chk("rst_aw_ready", bus.aw_ready, 1);
        chk("rst_w_ready", bus.w_ready, 1);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_b_valid", bus.b_valid, 0);
        chk("rst_r_data", bus.r_data, 0);
        chk("rst_r_resp", bus.r_resp, 0);
        chk("rst_b_resp", bus.b_resp, 0);
        step();
        rst = 1'b0;
        step();

        // Write then read back
        do_write(4'd3, 32'hDEADBEEF, 1'b0);
        do_read(4'd3, 32'hDEADBEEF, 1'b0);

        // W three cycles ahead of AW
        bus.w_valid = 1'b1;
        bus.w_data  = 32'h11;
        bus.b_ready = 1'b1;
        step();
        bus.w_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wfirst_w_ready", bus.w_ready, 0);
            chk("wfirst_aw_ready", bus.aw_ready, 1);
            chk("wfirst_b_valid", bus.b_valid, 0);
            step();
        end
        chk("wfirst_w_ready", bus.w_ready, 0);
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd5;
        step();
        bus.aw_valid = 1'b0;
        chk("wfirst_b_valid", bus.b_valid, 1);
        chk("wfirst_b_resp", bus.b_resp, 0);
        step();
        do_read(4'd5, 32'h11, 1'b0);

        // AW three cycles ahead of W
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd6;
        step();
        bus.aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("awfirst_aw_ready", bus.aw_ready, 0);
            chk("awfirst_w_ready", bus.w_ready, 1);
            chk("awfirst_b_valid", bus.b_valid, 0);
            step();
        end
        bus.w_valid = 1'b1;
        bus.w_data  = 32'h22;
        step();
        bus.w_valid = 1'b0;
        chk("awfirst_b_valid", bus.b_valid, 1);
        chk("awfirst_b_resp", bus.b_resp, 0);
        step();
        do_read(4'd6, 32'h22, 1'b0);

        // Out of range with a fresh memory
        do_reset();
        bus.arr_size = 4'd4;
        do_write(4'd4, 32'h55, 1'b1);
        do_read(4'd4, 32'h0, 1'b1);
        do_read(4'd3, 32'h0, 1'b0);

        // Backpressure on both response channels
        bus.arr_size = 4'd8;
        do_write(4'd1, 32'hAB, 1'b0);
        bus.ar_valid   = 1'b1;
        bus.ar_address = 4'd1;
        bus.r_ready    = 1'b0;
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd0;
        bus.w_valid    = 1'b1;
        bus.w_data     = 32'h5;
        bus.b_ready    = 1'b0;
        step();
        bus.ar_valid = 1'b0;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_r_valid", bus.r_valid, 1);
            chk("bp_r_data", bus.r_data, 32'hAB);
            chk("bp_b_valid", bus.b_valid, 1);
            chk("bp_b_resp", bus.b_resp, 0);
            chk("bp_ar_ready", bus.ar_ready, 0);
            chk("bp_aw_ready", bus.aw_ready, 0);
            chk("bp_w_ready", bus.w_ready, 0);
            step();
        end
        bus.r_ready = 1'b1;
        bus.b_ready = 1'b1;
        step();
        chk("bp_r_release", bus.r_valid, 0);
        chk("bp_b_release", bus.b_valid, 0);
        do_read(4'd0, 32'h5, 1'b0);

        // Read and write to the same word on the same edge
        do_write(4'd2, 32'd7, 1'b0);
        bus.ar_valid   = 1'b1;
        bus.ar_address = 4'd2;
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd2;
        bus.w_valid    = 1'b1;
        bus.w_data     = 32'd9;
        step();
        bus.ar_valid = 1'b0;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        chk("col_r_data", bus.r_data, 32'd7);
        chk("col_b_valid", bus.b_valid, 1);
        step();
        do_read(4'd2, 32'd9, 1'b0);

        // Reset with AW captured and a read response pending
        bus.aw_valid   = 1'b1;
        bus.aw_address = 4'd7;
        bus.ar_valid   = 1'b1;
        bus.ar_address = 4'd0;
        bus.r_ready    = 1'b0;
        step();
        bus.aw_valid = 1'b0;
        bus.ar_valid = 1'b0;
        chk("mid_aw_held", bus.aw_ready, 0);
        chk("mid_r_valid", bus.r_valid, 1);
        bus.w_data = 32'h77;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_r_drop", bus.r_valid, 0);
        chk("mid_ar_ready", bus.ar_ready, 1);
        chk("mid_aw_ready", bus.aw_ready, 1);
        chk("mid_w_ready", bus.w_ready, 1);
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_b", bus.b_valid, 0);
            step();
        end
        do_read(4'd7, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/sort_mem_responder.md
# sort_mem_responder

Memory-side responder for the insertion-sort datapath. Holds the array being sorted as 2^ADDR_WDTH words of DATA_WDTH bits and serves the datapath's read (AR/R) and write (AW/W/B) transactions with valid/ready handshakes. Addresses at or above `arr_size` get an error response. Each read and write path runs its own small FSM, so one read and one write can be in flight at the same time.

## Interface

Parameters:
- ADDR_WDTH, 4, address width; depth = 2^ADDR_WDTH words
- DATA_WDTH, 32, data word width
- RESP_WDTH, 1, response width; 0 = OK, 1 = out-of-range error (zero-extended if wider)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- arr_size  in  ADDR_WDTH  number of valid words; address a is valid iff a < arr_size
- ar_valid / ar_ready  in / out  1  read-address handshake
- ar_address  in  ADDR_WDTH  read word address
- r_valid / r_ready  out / in  1  read-data handshake
- r_data  out  DATA_WDTH  read data
- r_resp  out  RESP_WDTH  read response
- aw_valid / aw_ready  in / out  1  write-address handshake
- aw_address  in  ADDR_WDTH  write word address
- w_valid / w_ready  in / out  1  write-data handshake
- w_data  in  DATA_WDTH  write data
- b_valid / b_ready  out / in  1  write-response handshake
- b_resp  out  RESP_WDTH  write response

## Operation

- A handshake completes on a rising edge where both valid and ready are 1.
- Storage is a register array. Reset clears every word to 0.

Read FSM, states R_IDLE and R_RESP:
- R_IDLE: ar_ready=1, r_valid=0.
- On AR handshake, register r_data and r_resp, then go to R_RESP.
  - In range: r_data = mem[ar_address], r_resp = 0.
  - Out of range: r_data = 0, r_resp = 1.
- R_RESP: ar_ready=0, r_valid=1. r_data and r_resp stay stable until the R handshake.
- On R handshake, go to R_IDLE.

Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
- W_IDLE: aw_ready=1, w_ready=1.
  - AW and W in the same cycle: capture both, go straight to the commit step.
  - Only one of them: capture it and go to W_HAVE_AW or W_HAVE_W.
- W_HAVE_AW: aw_ready=0, w_ready=1. Waits for W.
- W_HAVE_W: aw_ready=1, w_ready=0. Waits for AW.
- Commit, on the edge where the second half is captured:
  - In range: mem[addr] <= data, b_resp = 0.
  - Out of range: memory unchanged, b_resp = 1.
  - Go to W_RESP.
- W_RESP: aw_ready=0, w_ready=0, b_valid=1. On B handshake, go to W_IDLE.
- The range check uses arr_size as sampled on the commit edge.

Simultaneous events:
- A read captured on the same edge a write commits to the same address returns the old word.
- A read handshaken on any later edge sees the new word.

Reset mid-operation:
- All FSMs return to idle.
- Any captured AW/W half is discarded and no write commits.
- Any pending r_valid or b_valid drops immediately.

## Timing

- Reset values: ar_ready=1, aw_ready=1, w_ready=1, r_valid=0, b_valid=0, r_data=0, r_resp=0, b_resp=0, all memory words 0.
- All outputs are driven from registers or decoded from FSM state. There is no combinational path from any input to any output.
- Read latency: r_valid rises 1 cycle after the AR handshake edge.
  - Back-to-back reads: the next AR handshake can occur no earlier than 1 cycle after the R handshake.
  - Read throughput is therefore 1 read per 2 cycles when r_ready is held at 1.
- Write latency: b_valid rises 1 cycle after the edge that completes the second of AW/W.
  - Write throughput is 1 write per 2 cycles with AW, W and b_ready all held at 1.
- Backpressure: r_valid and b_valid stay high, with stable data and response, for as long as the ready input is 0.

## Test plan

- Write followed by read: reset, arr_size=8, write 0xDEADBEEF to address 3 (AW and W in the same cycle), then read address 3. Required: b_valid one cycle after the handshake with b_resp=0; r_data=0xDEADBEEF, r_resp=0, r_valid one cycle after the AR handshake.
- AW/W ordering: W with 0x11 arrives 3 cycles before AW to address 5. Required: w_ready=0 while waiting; commit happens on the AW edge; a later read of address 5 returns 0x11. Repeat with AW arriving first.
- Out of range: arr_size=4.
  - Write 0x55 to address 4: required b_resp=1.
  - Read address 4: required r_resp=1, r_data=0.
  - Read address 3: required value unchanged (0 after reset).
- Backpressure: hold r_ready=0 and b_ready=0 for 5 cycles. Required: r_valid, r_data, b_valid and b_resp stay stable; ar_ready=0, aw_ready=0 and w_ready=0 throughout.
- Read/write collision: mem[2]=7. A write of 9 to address 2 commits on the same edge as an AR handshake for address 2. Required: r_data=7; the next read of address 2 returns 9.
- Mid-transaction reset: AW captured, W pending, and r_valid=1. Assert rst asynchronously. Required: r_valid=0 immediately; all readies return to 1; the target word stays 0; no b_valid after rst is released.
